// File: rtl/jtoutrun_motor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtoutrun_motor_pkg
// Description : Shared state codes, ctrl-byte encoding and travel limits for
//               the Out Run steering motor controller and its motor model.
// Revision    : 1.0 - initial release
// ============================================================================
package jtoutrun_motor_pkg;

    typedef logic [1:0] state_t;

    localparam state_t HOME_L = 2'd0;
    localparam state_t HOME_C = 2'd1;
    localparam state_t TRACK  = 2'd2;
    localparam state_t FAULT  = 2'd3;

    localparam logic [7:0]  CTRL_STOP    = 8'h08;
    localparam int          CTRL_DIR_BIT = 3;
    localparam logic [15:0] LEFTLIM_DEF  = 16'h2000;
    localparam logic [15:0] RIGHTLIM_DEF = 16'hE000;

    // Left speeds are sent inverted; speed 0 always maps to the stop code.
    function automatic logic [7:0] ctrl_encode(input logic dir, input logic [2:0] spd);
        logic [7:0] c;
        c               = 8'h00;
        c[CTRL_DIR_BIT] = dir;
        c[2:0]          = dir ? spd : ~spd;
        if (spd == 3'd0) c = CTRL_STOP;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtoutrun_motdrv_speed.sv
`default_nettype none
// ============================================================================
// Module      : jtoutrun_motdrv_speed
// Description : Combinational target/position to {direction, speed} mapper
//               with clamping, deadband, saturation and limit inhibit.
// Revision    : 1.0 - initial release
// ============================================================================
module jtoutrun_motdrv_speed
    import jtoutrun_motor_pkg::*;
#(
    parameter logic [15:0] DEADBAND = 16'h0040,
    parameter logic [15:0] LEFTLIM  = LEFTLIM_DEF,
    parameter logic [15:0] RIGHTLIM = RIGHTLIM_DEF
) (
    input  logic [15:0] target_i,
    input  logic [15:0] pos_i,
    input  logic        lim_l_n_i,
    input  logic        lim_r_n_i,
    output logic        dir_o,
    output logic [2:0]  spd_o
);

    logic [15:0] tgt_w;
    logic [16:0] err_w;
    logic [16:0] mag_w;

    always_comb begin
        tgt_w = target_i;
        if (target_i < LEFTLIM)       tgt_w = LEFTLIM;
        else if (target_i > RIGHTLIM) tgt_w = RIGHTLIM;

        // 17-bit difference so the full 16-bit range never wraps
        err_w = {1'b0, tgt_w} - {1'b0, pos_i};
        mag_w = err_w[16] ? (~err_w + 17'd1) : err_w;
        dir_o = ~err_w[16];

        spd_o = (mag_w[16:5] >= 12'd7) ? 3'd7 : mag_w[7:5];
        if (mag_w < {1'b0, DEADBAND})             spd_o = 3'd0;
        if (!err_w[16] && !lim_r_n_i)             spd_o = 3'd0;
        if (err_w[16] && !lim_l_n_i)              spd_o = 3'd0;
    end

endmodule
`default_nettype wire

// File: rtl/jtoutrun_motdrv.sv
`default_nettype none
// ============================================================================
// Module      : jtoutrun_motdrv
// Description : Out Run steering motor controller: homes left then centre,
//               then tracks the target once per vertical interrupt.
//               Optional macro JTOUTRUN_MOTDRV_SLEW_EN adds speed slew limit.
// Revision    : 1.0 - initial release
// ============================================================================
module jtoutrun_motdrv
    import jtoutrun_motor_pkg::*;
#(
    parameter logic [7:0]  TOUT     = 8'd255,
    parameter logic [15:0] DEADBAND = 16'h0040,
    parameter logic [15:0] LEFTLIM  = LEFTLIM_DEF,
    parameter logic [15:0] RIGHTLIM = RIGHTLIM_DEF
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        vint,
    input  logic        enable,
    input  logic [15:0] target,
    input  logic [15:0] pos,
    input  logic [2:0]  limpos,
    output logic [7:0]  ctrl,
    output logic        ready,
    output logic        fault
);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic        vint_q;

    logic        tick_w;
    logic        trk_dir_w;
    logic [2:0]  trk_spd_w;
    logic [7:0]  cnt_inc_w;
    logic        drive_w;
    logic        want_dir_w;
    logic [2:0]  want_spd_w;
    logic [2:0]  app_spd_w;

`ifdef JTOUTRUN_MOTDRV_SLEW_EN
    logic [2:0]  spd_q, spd_d;
    logic        dir_q, dir_d;
`endif

    assign tick_w    = vint & ~vint_q;
    assign cnt_inc_w = cnt_q + 8'd1;

    jtoutrun_motdrv_speed #(
        .DEADBAND (DEADBAND),
        .LEFTLIM  (LEFTLIM),
        .RIGHTLIM (RIGHTLIM)
    ) u_speed (
        .target_i  (target),
        .pos_i     (pos),
        .lim_l_n_i (limpos[2]),
        .lim_r_n_i (limpos[0]),
        .dir_o     (trk_dir_w),
        .spd_o     (trk_spd_w)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ctrl_d     = ctrl_q;
        drive_w    = 1'b0;
        want_dir_w = 1'b0;
        want_spd_w = 3'd0;
        app_spd_w  = 3'd0;
`ifdef JTOUTRUN_MOTDRV_SLEW_EN
        spd_d      = spd_q;
        dir_d      = dir_q;
`endif
        if (!enable) begin
            ctrl_d = CTRL_STOP;
`ifdef JTOUTRUN_MOTDRV_SLEW_EN
            spd_d  = 3'd0;
`endif
        end else if (tick_w) begin
            // Both end switches at once means broken wiring: stop for good
            if (state_q != FAULT && !limpos[2] && !limpos[0]) begin
                state_d = FAULT;
            end else begin
                case (state_q)
                    HOME_L: begin
                        if (!limpos[2]) begin
                            state_d = HOME_C;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d = cnt_inc_w;
                            if (cnt_inc_w == TOUT) state_d = FAULT;
                            else begin
                                drive_w    = 1'b1;
                                want_dir_w = 1'b0;
                                want_spd_w = 3'd7;
                            end
                        end
                    end
                    HOME_C: begin
                        if (!limpos[1]) begin
                            state_d = TRACK;
                        end else begin
                            cnt_d = cnt_inc_w;
                            if (cnt_inc_w == TOUT) state_d = FAULT;
                            else begin
                                drive_w    = 1'b1;
                                want_dir_w = 1'b1;
                                want_spd_w = 3'd7;
                            end
                        end
                    end
                    TRACK: begin
                        drive_w    = 1'b1;
                        want_dir_w = trk_dir_w;
                        want_spd_w = trk_spd_w;
                    end
                    default: ;
                endcase
            end

`ifdef JTOUTRUN_MOTDRV_SLEW_EN
            // Ramp up one step per frame; reversing passes through one stop frame
            if (want_spd_w == 3'd0 || (spd_q != 3'd0 && want_dir_w != dir_q))
                app_spd_w = 3'd0;
            else if (want_spd_w > spd_q)
                app_spd_w = spd_q + 3'd1;
            else
                app_spd_w = want_spd_w;
            spd_d = drive_w ? app_spd_w : 3'd0;
            dir_d = want_dir_w;
`else
            app_spd_w = want_spd_w;
`endif
            ctrl_d = drive_w ? ctrl_encode(want_dir_w, app_spd_w) : CTRL_STOP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HOME_L;
            cnt_q   <= 8'd0;
            ctrl_q  <= CTRL_STOP;
            vint_q  <= 1'b0;
`ifdef JTOUTRUN_MOTDRV_SLEW_EN
            spd_q   <= 3'd0;
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            vint_q  <= vint;
`ifdef JTOUTRUN_MOTDRV_SLEW_EN
            spd_q   <= spd_d;
            dir_q   <= dir_d;
`endif
        end
    end

    assign ctrl  = ctrl_q;
    assign ready = (state_q == TRACK);
    assign fault = (state_q == FAULT);

endmodule
`default_nettype wire

// File: tb/tb_jtoutrun_motdrv.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtoutrun_motdrv
// Description : Scoreboard bench for jtoutrun_motdrv with a frame-level
//               reference model and a simple steering motor model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtoutrun_motdrv;

`ifdef JTOUTRUN_MOTDRV_SLEW_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vint = 1'b0;
    logic        enable = 1'b1;
    logic [15:0] target = 16'h8000;
    logic [15:0] pos = 16'h8000;
    logic [2:0]  limpos = 3'b111;
    logic [7:0]  ctrl;
    logic        ready;
    logic        fault;

    always #5 clk = ~clk;

    jtoutrun_motdrv dut (
        .rst    (rst),
        .clk    (clk),
        .vint   (vint),
        .enable (enable),
        .target (target),
        .pos    (pos),
        .limpos (limpos),
        .ctrl   (ctrl),
        .ready  (ready),
        .fault  (fault)
    );

    typedef struct {
        logic [7:0] ctrl;
        logic       ready;
        logic       fault;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;

    // reference model: phase 0 home-left, 1 home-centre, 2 track, 3 fault
    int   m_phase, m_cnt, m_prev;
    bit   m_pdir;
    int   mot_pos;
    bit   mot_run;

    task automatic check(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic int desired_speed(input int tgt, input int p, input logic [2:0] lim,
                                         output bit dir);
        int t, e, m;
        t   = (tgt < 'h2000) ? 'h2000 : ((tgt > 'hE000) ? 'hE000 : tgt);
        e   = t - p;
        m   = (e < 0) ? -e : e;
        dir = (e > 0);
        if (m < 'h40) return 0;
        if (e > 0 && !lim[0]) return 0;
        if (e < 0 && !lim[2]) return 0;
        return (m / 32 > 7) ? 7 : m / 32;
    endfunction

    task automatic apply(input bit dir, input int s, output logic [7:0] c);
        int a;
        a = s;
        if (SLEW) begin
            if (s == 0 || (m_prev != 0 && dir != m_pdir)) a = 0;
            else if (s > m_prev + 1) a = m_prev + 1;
        end
        m_prev = a;
        m_pdir = dir;
        if (a == 0) c = 8'h08;
        else if (dir) c = 8'(8 + a);
        else c = 8'(7 - a);
    endtask

    task automatic model_tick(output exp_t e);
        logic [7:0] c;
        bit d;
        int s;
        c = 8'h08;
        if (!enable) begin
            m_prev = 0;
        end else if (m_phase != 3 && !limpos[2] && !limpos[0]) begin
            m_phase = 3;
            m_prev  = 0;
        end else begin
            case (m_phase)
                0: if (!limpos[2]) begin
                       m_phase = 1; m_cnt = 0; m_prev = 0;
                   end else begin
                       m_cnt++;
                       if (m_cnt >= 255) begin m_phase = 3; m_prev = 0; end
                       else apply(1'b0, 7, c);
                   end
                1: if (!limpos[1]) begin
                       m_phase = 2; m_prev = 0;
                   end else begin
                       m_cnt++;
                       if (m_cnt >= 255) begin m_phase = 3; m_prev = 0; end
                       else apply(1'b1, 7, c);
                   end
                2: begin
                       s = desired_speed(int'(target), int'(pos), limpos, d);
                       apply(d, s, c);
                   end
                default: m_prev = 0;
            endcase
        end
        e.ctrl  = c;
        e.ready = (m_phase == 2);
        e.fault = (m_phase == 3);
    endtask

    function automatic logic [2:0] motor_lim(input int p);
        int hi;
        hi = p >> 8;
        return {hi > 'h20, hi != 'h80, hi < 'hE0};
    endfunction

    task automatic motor_move(input logic [7:0] c);
        if (c != 8'h08) begin
            if (c[3]) mot_pos += 32 * int'(c[2:0]);
            else      mot_pos -= 32 * (7 - int'(c[2:0]));
        end
        if (mot_pos < 0) mot_pos = 0;
        if (mot_pos > 65535) mot_pos = 65535;
    endtask

    task automatic frame();
        exp_t e;
        @(negedge clk);
        if (mot_run) begin
            pos    = 16'(mot_pos);
            limpos = motor_lim(mot_pos);
        end
        vint = 1'b1;
        model_tick(e);
        expq.push_back(e);
        repeat (3) @(negedge clk);
        vint = 1'b0;
        repeat (2) @(negedge clk);
        if (mot_run) motor_move(e.ctrl);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        vint = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", int'(ctrl), 'h08);
        check("reset_ready", int'(ready), 0);
        check("reset_fault", int'(fault), 0);
        rst = 1'b0;
        m_phase = 0; m_cnt = 0; m_prev = 0; m_pdir = 1'b0;
    endtask

    // monitor: each frame tick yields one response, visible one clk later
    initial begin : monitor
        exp_t me;
        forever begin
            @(posedge vint);
            @(posedge clk);
            #1;
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard: response with no expectation at %0t", $time);
            end else begin
                me = expq.pop_front();
                check("ctrl", int'(ctrl), int'(me.ctrl));
                check("ready", int'(ready), int'(me.ready));
                check("fault", int'(fault), int'(me.fault));
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [15:0] dir_tgts [6];
        dir_tgts = '{16'hA000, 16'h8060, 16'h7FA0, 16'h8020, 16'h8000, 16'hC000};

        // homing from centre with the motor model attached
        mot_run = 1'b0;
        do_reset();
        mot_run = 1'b1;
        mot_pos = 'h8000;
        for (int i = 0; i < 700 && m_phase != 2; i++) frame();
        check("home_ready", int'(ready), 1);

        // directed tracking with frozen position
        mot_run = 1'b0;
        pos     = 16'h8000;
        limpos  = 3'b111;
        for (int i = 0; i < 6; i++) begin
            target = dir_tgts[i];
            repeat (SLEW ? 9 : 2) frame();
        end

        // clamp and right-limit inhibit, then clamped left drive to the limit
        target = 16'hFFFF; pos = 16'hE000; limpos = 3'b110;
        repeat (3) frame();
        target  = 16'h0000;
        mot_pos = 'h8000;
        mot_run = 1'b1;
        repeat (130) frame();
        mot_run = 1'b0;

        // random tracking, never both end switches together
        for (int i = 0; i < 200; i++) begin
            target = 16'($urandom);
            pos    = 16'($urandom);
            case ($urandom_range(0, 3))
                0: limpos = 3'b111;
                1: limpos = 3'b011;
                2: limpos = 3'b110;
                default: limpos = 3'b101;
            endcase
            frame();
        end

        // both end switches: terminal fault
        limpos = 3'b010;
        repeat (2) frame();
        limpos = 3'b111;
        target = 16'hA000;
        repeat (3) frame();

        // homing timeout with no switch ever asserting
        do_reset();
        pos = 16'h8000; limpos = 3'b111;
        repeat (255) frame();
        check("tout_fault", int'(fault), 1);
        repeat (100) frame();
        check("tout_hold_ctrl", int'(ctrl), 'h08);

        // enable dropped during HOME_L; counter must stay frozen
        do_reset();
        mot_run = 1'b1;
        mot_pos = 'h8000;
        repeat (20) frame();
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1 check("disable_ctrl", int'(ctrl), 'h08);
        repeat (50) frame();
        enable = 1'b1;
        repeat (30) frame();
        enable = 1'b0;
        repeat (160) frame();
        enable = 1'b1;
        for (int i = 0; i < 700 && m_phase != 2; i++) frame();
        check("reenable_fault", int'(fault), 0);
        check("reenable_ready", int'(ready), 1);

        // speed ramp and reversal (slew build differs only in expectations)
        mot_run = 1'b0;
        pos = 16'h8000; limpos = 3'b111;
        target = 16'h8000;
        repeat (2) frame();
        target = 16'hC000;
        repeat (9) frame();
        target = 16'h4000;
        repeat (10) frame();

        repeat (5) @(negedge clk);
        check("queue_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
